// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the CPU memory responder slice.
package cpu_mem_pkg;

  localparam int unsigned WordW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit (master) and the memory responder (slave).
interface mem_responder_if;
  import cpu_mem_pkg::*;

  logic             mem_read;
  logic             mem_write;
  logic [WordW-1:0] addr;
  logic [WordW-1:0] wdata;
  logic [WordW-1:0] rdata;
  logic             done;
  logic             busy;
  logic             err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, done, busy, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, done, busy, err
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM with a registered read port (read-before-write).
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WordW-1:0]  wdata,
  output logic [WordW-1:0]  rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [WordW-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures one read/write request, waits WAIT_CYCLES, then completes
// the access with a one-cycle done (and err for rejected requests).
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WordW-1:0]  wdata_q;
  op_e               op_q;
  logic              err_q;
  logic [WordW-1:0]  rdata_q, rdata_d;

  logic              req, req_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [WordW-1:0]  acc_wdata;
  logic              acc_write, acc_err;
  logic              mem_we;
  logic [WordW-1:0]  mem_rdata;

  assign req     = bus.mem_read | bus.mem_write;
  assign req_err = (bus.mem_read & bus.mem_write) | (|(bus.addr >> ADDR_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = CntLoad;
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OpRead;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (state_q == StIdle && req) begin
        addr_q  <= bus.addr[ADDR_W-1:0];
        wdata_q <= bus.wdata;
        op_q    <= bus.mem_write ? OpWrite : OpRead;
        err_q   <= req_err;
      end
    end
  end

  // With no wait states the access happens on the capture edge, so use the live request.
  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = bus.addr[ADDR_W-1:0];
      acc_wdata = bus.wdata;
      acc_write = bus.mem_write;
      acc_err   = req_err;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_write = (op_q == OpWrite);
      acc_err   = err_q;
    end
  end

  assign mem_we = (state_d == StResp) & acc_write & ~acc_err & ~reset;

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    bus.done  = (state_q == StResp);
    bus.busy  = (state_q != StIdle);
    bus.err   = bus.done & err_q;
    rdata_d   = rdata_q;
    if (bus.done && op_q == OpRead && !err_q) begin
      rdata_d = mem_rdata;
    end
    bus.rdata = rdata_d;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one DUT with two wait states, one with none.
module tb_mem_responder;
  import cpu_mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  exp_t sb[$];
  exp_t sb0[$];
  bit [31:0] mdl  [int];
  bit [31:0] mdl0 [int];
  logic [31:0] last_rd  = '0;
  logic [31:0] last_rd0 = '0;

  // Scoreboard: every done pops one expected response; stray done or err is an error.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.done === 1'b1) begin
      done_cnt++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done dut: got done=1, required no response pending");
      end else begin
        e = sb.pop_front();
        if (bus.rdata !== e.rdata || bus.err !== e.err) begin
          miscompares++;
          $display("FAIL response dut: got rdata=%h err=%b, required rdata=%h err=%b",
                   bus.rdata, bus.err, e.rdata, e.err);
        end
      end
    end else if (bus.err === 1'b1) begin
      miscompares++;
      $display("FAIL err_without_done dut: got err=1, required 0");
    end
    if (bus0.done === 1'b1) begin
      vectors++;
      if (sb0.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done dut0: got done=1, required no response pending");
      end else begin
        e = sb0.pop_front();
        if (bus0.rdata !== e.rdata || bus0.err !== e.err) begin
          miscompares++;
          $display("FAIL response dut0: got rdata=%h err=%b, required rdata=%h err=%b",
                   bus0.rdata, bus0.err, e.rdata, e.err);
        end
      end
    end
  end

  // One access; expected result comes from the bench's own memory model.
  task automatic access(input bit w0, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   k;
    int   lat;
    logic dn;
    lat   = w0 ? 1 : 3;
    e.err = (rd && wr) || ((a >> 9) != 0);
    if (!e.err) begin
      if (rd) begin
        if (w0) last_rd0 = mdl0.exists(int'(a)) ? mdl0[int'(a)] : 32'h0;
        else    last_rd  = mdl.exists(int'(a))  ? mdl[int'(a)]  : 32'h0;
      end else begin
        if (w0) mdl0[int'(a)] = d;
        else    mdl[int'(a)]  = d;
      end
    end
    e.rdata = w0 ? last_rd0 : last_rd;
    if (w0) begin
      sb0.push_back(e);
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.wdata = d;
    end else begin
      sb.push_back(e);
      bus.mem_read = rd; bus.mem_write = wr; bus.addr = a; bus.wdata = d;
    end
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus0.mem_read = 1'b0; bus0.mem_write = 1'b0;
    k  = 1;
    dn = w0 ? bus0.done : bus.done;
    while (dn !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
      dn = w0 ? bus0.done : bus.done;
    end
    vectors++;
    if (k != lat) begin
      miscompares++;
      $display("FAIL latency a=%h: done in cycle %0d after request edge, required %0d", a, k, lat);
    end
    @(posedge clk); #1;
    if (dn !== 1'b1) begin
      if (w0) sb0.delete(); else sb.delete();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    last_rd  = '0;
    last_rd0 = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors += 2;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state dut: got busy=%b done=%b err=%b rdata=%h, required 0 0 0 0",
               bus.busy, bus.done, bus.err, bus.rdata);
    end
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state dut0: got busy=%b done=%b rdata=%h, required 0 0 0",
               bus0.busy, bus0.done, bus0.rdata);
    end
  endtask

  task automatic test_clear();
    access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
  endtask

  task automatic test_write();
    access(1'b0, 1'b0, 1'b1, 32'h5, 32'hDEADBEEF);
  endtask

  task automatic test_read_hold();
    access(1'b0, 1'b1, 1'b0, 32'h5, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.rdata !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL rdata_hold idle %0d: got %h, required deadbeef", i, bus.rdata);
      end
    end
  endtask

  task automatic test_out_of_range();
    access(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
    access(1'b0, 1'b0, 1'b1, 32'h201, 32'h55555555);
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_both_strobes();
    access(1'b0, 1'b1, 1'b1, 32'h10, 32'h1234);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_reset_mid();
    bus.mem_write = 1'b1; bus.addr = 32'h20; bus.wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    last_rd  = '0;
    last_rd0 = '0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b rdata=%h, required busy=0 rdata=0",
               bus.busy, bus.rdata);
    end
    repeat (4) @(posedge clk);
    #1;
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_busy_ignore();
    int   start;
    int   k;
    exp_t e;
    start   = done_cnt;
    last_rd = mdl[5];
    e.rdata = last_rd;
    e.err   = 1'b0;
    sb.push_back(e);
    bus.mem_read = 1'b1; bus.addr = 32'h5;
    @(posedge clk); #1;
    bus.addr = 32'h10;
    @(posedge clk); #1;
    bus.mem_read = 1'b0;
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt - start != 1) begin
      miscompares++;
      $display("FAIL busy_ignore: got %0d done pulses, required 1", done_cnt - start);
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    int   k;
    exp_t e;
    e.rdata = mdl[5];
    e.err   = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    bus.mem_read = 1'b1; bus.addr = 32'h5;
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (bus.done !== 1'b1 && k < 20);
    bus.mem_read = 1'b0;
    vectors++;
    if (k != 4) begin
      miscompares++;
      $display("FAIL back_to_back: done spacing %0d cycles, required 4", k);
      sb.delete();
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_wait0();
    access(1'b1, 1'b0, 1'b1, 32'h33, 32'hA5A5A5A5);
    access(1'b1, 1'b1, 1'b0, 32'h33, 32'h0);
    access(1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
  endtask

  initial begin
    bus.mem_read  = 1'b0; bus.mem_write  = 1'b0; bus.addr  = '0; bus.wdata  = '0;
    bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    test_reset();
    test_clear();
    test_write();
    test_read_hold();
    test_out_of_range();
    test_both_strobes();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    test_wait0();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0 || sb0.size() != 0) begin
      miscompares++;
      $display("FAIL missing_done: %0d/%0d responses outstanding, required 0/0",
               sb.size(), sb0.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
